// File: rtl/freqdiv_multi_if.sv
// Control and output bundle of the multi-channel clock divider.
// The master side programs divisors and gates counting; the slave side
// is the divider itself.
interface freqdiv_multi_if #(
   parameter int CH    = 2,
   parameter int SEL_W = 1,
   parameter int CNT_W = 26
);
   logic             en;
   logic             sync;
   logic             div_wr;
   logic [SEL_W-1:0] div_sel;
   logic [CNT_W-1:0] div_val;
   logic             div_err;
   logic [CH-1:0]    clk_out;
   logic [CH-1:0]    tick;

   modport master (
      output en, sync, div_wr, div_sel, div_val,
      input  div_err, clk_out, tick
   );

   modport slave (
      input  en, sync, div_wr, div_sel, div_val,
      output div_err, clk_out, tick
   );
endinterface

// File: rtl/freqdiv_multi.sv
// Multi-channel programmable clock divider.
// Each channel divides clk by its own runtime divisor and produces a ~50%
// duty square wave plus a one-cycle tick at the period wrap. Divisor writes
// land in a shadow register and take effect only at the next wrap or sync,
// so a period in progress is never cut short or stretched.
module freqdiv_multi #(
   parameter int CH      = 2,
   parameter int SEL_W   = 1,
   parameter int CNT_W   = 26,
   parameter int DEF_DIV = 500000
) (
   input  logic              clk,
   input  logic              rst,
   freqdiv_multi_if.slave    bus
);

   logic          val_ok_s;
   logic          sel_ok_s;
   logic          wr_ok_s;
   logic          wr_bad_s;
   logic          div_err_r;
   logic [CH-1:0] clk_out_s;
   logic [CH-1:0] tick_s;

   // Channel index check is only needed when the select field can address
   // more channels than exist.
   if ((1 << SEL_W) > CH) begin : g_sel_chk
      assign sel_ok_s = (32'(bus.div_sel) < CH);
   end else begin : g_sel_all
      assign sel_ok_s = 1'b1;
   end

   // Classify a divisor write as accepted or rejected.
   always_comb begin
      val_ok_s = (bus.div_val >= CNT_W'(2));
      if (bus.div_wr) begin
         wr_ok_s  = val_ok_s & sel_ok_s;
         wr_bad_s = ~(val_ok_s & sel_ok_s);
      end else begin
         wr_ok_s  = 1'b0;
         wr_bad_s = 1'b0;
      end
   end

   // One-cycle error pulse for a rejected write; writes during reset are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_err_r <= 1'b0;
      end else begin
         div_err_r <= wr_bad_s;
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_ch
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] div_r;
      logic [CNT_W-1:0] shd_r;
      logic             pend_r;
      logic             clk_out_r;
      logic             tick_r;
      logic [CNT_W-1:0] cnt_nxt_s;
      logic             wrap_s;
      logic             load_s;
      logic             wr_hit_s;

      // Next count, wrap detect, shadow-load and write-select decode.
      always_comb begin
         wrap_s = (cnt_r == (div_r - CNT_W'(1)));
         if (wrap_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
         end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
         end
         load_s   = pend_r & (bus.sync | (bus.en & wrap_s));
         wr_hit_s = wr_ok_s & (bus.div_sel == SEL_W'(g));
      end

      // Counter, divisor bookkeeping and registered outputs for one channel.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            div_r     <= CNT_W'(DEF_DIV);
            shd_r     <= {CNT_W{1'b0}};
            pend_r    <= 1'b0;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
         end else begin
            if (bus.sync) begin
               cnt_r     <= {CNT_W{1'b0}};
               clk_out_r <= 1'b0;
               tick_r    <= 1'b0;
            end else if (bus.en) begin
               cnt_r     <= cnt_nxt_s;
               tick_r    <= wrap_s;
               // Threshold uses the divisor of the period just finishing,
               // so a reload at the wrap cannot glitch the output.
               clk_out_r <= (cnt_nxt_s >= (div_r >> 1));
            end else begin
               tick_r    <= 1'b0;
            end
            if (load_s) begin
               div_r <= shd_r;
            end
            // A write on the same edge as a load re-arms the pending flag,
            // so the new value waits for the following wrap or sync.
            if (wr_hit_s) begin
               shd_r  <= bus.div_val;
               pend_r <= 1'b1;
            end else if (load_s) begin
               pend_r <= 1'b0;
            end
         end
      end

      assign clk_out_s[g] = clk_out_r;
      assign tick_s[g]    = tick_r;
   end

   assign bus.clk_out = clk_out_s;
   assign bus.tick    = tick_s;
   assign bus.div_err = div_err_r;

endmodule
